// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package systolic_pkg;

    // Job phases of the sequencer.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    localparam int DEF_N     = 4;
    localparam int DEF_K_MAX = 256;

    // FEED lasts k_len cycles of operand entry for the last lane, plus the
    // skew of N-1 lanes and another N-1 cycles to flush to PE(N-1,N-1).
    function automatic int feed_len(input int k, input int n);
        return k + 2 * n - 2;
    endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Combinational skew generator: lane i sees operand index t-i while
// i <= t <= i+k_len-1, and is idle (index 0) otherwise.
module systolic_skew_gen
    import systolic_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int KW = 9,
    parameter int AW = 8,
    parameter int TW = 9
) (
    input  logic [TW-1:0]   i_t,
    input  logic [KW-1:0]   i_k_len,
    output logic [N-1:0]    o_lane_en,
    output logic [N*AW-1:0] o_lane_k
);

    // One extra bit so i+k_len cannot wrap for the last lanes.
    logic [TW:0] w_t_ext;
    assign w_t_ext = {1'b0, i_t};

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [TW:0] w_lo;
            logic [TW:0] w_hi;
            logic [TW:0] w_diff;
            logic        w_active;

            assign w_lo     = (TW+1)'(gi);
            assign w_hi     = w_lo + (TW+1)'(i_k_len);
            assign w_active = (w_t_ext >= w_lo) && (w_t_ext < w_hi);
            assign w_diff   = w_t_ext - w_lo;

            assign o_lane_en[gi]          = w_active;
            // t-i only matters inside the active window, where it is < k_len <= K_MAX.
            assign o_lane_k[gi*AW +: AW]  = w_active ? w_diff[AW-1:0] : '0;
        end
    endgenerate

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: clears the
// accumulators, feeds skewed operand indices, then drains result rows.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int K_MAX = DEF_K_MAX,
    parameter int KW    = $clog2(K_MAX + 1),
    parameter int AW    = $clog2(K_MAX)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    output logic                 busy,
    output logic                 done,
    output logic                 acc_clr,
    output logic                 array_en,
    output logic [N-1:0]         lane_en,
    output logic [N*AW-1:0]      lane_k,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_row
);

    localparam int TW = $clog2(K_MAX + 2 * N);
    localparam int RW = $clog2(N);

    seq_state_t      r_state;
    seq_state_t      w_state_next;
    logic [TW-1:0]   r_t;
    logic [TW-1:0]   w_t_next;
    logic [TW-1:0]   w_t_last;
    logic [KW-1:0]   r_k_len;
    logic [KW-1:0]   w_k_next;
    logic [RW-1:0]   r_out_row;
    logic [RW-1:0]   w_row_next;

    logic            r_busy;
    logic            r_done;
    logic            r_acc_clr;
    logic            r_array_en;
    logic            r_out_valid;
    logic [N-1:0]    r_lane_en;
    logic [N*AW-1:0] r_lane_k;

    logic [N-1:0]    w_skew_en;
    logic [N*AW-1:0] w_skew_k;

    // Last FEED cycle index.
    assign w_t_last = TW'(feed_len(int'(r_k_len), N) - 1);

    // Lane indices are computed for the upcoming t so they can be registered
    // alongside the state they belong to.
    systolic_skew_gen #(
        .N  (N),
        .KW (KW),
        .AW (AW),
        .TW (TW)
    ) u_skew (
        .i_t       (w_t_next),
        .i_k_len   (r_k_len),
        .o_lane_en (w_skew_en),
        .o_lane_k  (w_skew_k)
    );

    // Next-state, FEED counter and drain row sequencing.
    always_comb begin
        w_state_next = r_state;
        w_t_next     = r_t;
        w_k_next     = r_k_len;
        w_row_next   = r_out_row;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_k_next     = k_len;
                    w_state_next = CLEAR;
                end
            end
            CLEAR: begin
                w_t_next     = '0;
                w_row_next   = '0;
                w_state_next = (r_k_len != '0) ? FEED : DRAIN;
            end
            FEED: begin
                if (r_t == w_t_last) begin
                    w_t_next     = '0;
                    w_state_next = DRAIN;
                end else begin
                    w_t_next = r_t + TW'(1);
                end
            end
            DRAIN: begin
                if (r_out_valid && out_ready) begin
                    if (r_out_row == RW'(N - 1)) begin
                        w_row_next   = '0;
                        w_state_next = DONE;
                    end else begin
                        w_row_next = r_out_row + RW'(1);
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_t         <= '0;
            r_k_len     <= '0;
            r_out_row   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_array_en  <= 1'b0;
            r_out_valid <= 1'b0;
            r_lane_en   <= '0;
            r_lane_k    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_t         <= w_t_next;
            r_k_len     <= w_k_next;
            r_out_row   <= w_row_next;
            r_busy      <= (w_state_next == CLEAR) || (w_state_next == FEED) ||
                           (w_state_next == DRAIN);
            r_done      <= (w_state_next == DONE);
            r_acc_clr   <= (w_state_next == CLEAR);
            r_array_en  <= (w_state_next == FEED);
            r_out_valid <= (w_state_next == DRAIN);
            r_lane_en   <= (w_state_next == FEED) ? w_skew_en : '0;
            r_lane_k    <= (w_state_next == FEED) ? w_skew_k : '0;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign acc_clr   = r_acc_clr;
    assign array_en  = r_array_en;
    assign lane_en   = r_lane_en;
    assign lane_k    = r_lane_k;
    assign out_valid = r_out_valid;
    assign out_row   = r_out_row;

endmodule
